// File: rtl/iic_target.sv
// -----------------------------------------------------------------------------
// iic_target
//
// I2C target (responder) with 7-bit addressing. It shares the open-drain
// SDA/SCL pair with our IIC initiator and never stretches the clock.
// SCL and SDA are oversampled on i_clk. The block detects START and STOP
// conditions, matches a 7-bit address, ACKs and delivers written bytes, and
// serves read bytes taken from a byte-wide user interface.
//
// Parameters:
//   TARGET_ADDR  7-bit bus address this target answers to.
//   SYNC_STAGES  synchronizer depth on SCL and SDA. Must be at least 2.
//
// Ports:
//   i_clk       system clock. Must run at least 10x the SCL rate.
//   i_rst       synchronous, active-low reset.
//   i_SCL       bus clock. Observed only, never driven.
//   io_SDA      bus data. Driven to 1'b0 or released to 1'bz, never 1'b1.
//   i_tx_data   byte returned to the initiator on reads.
//   o_tx_req    one-cycle pulse requesting the next i_tx_data.
//   o_rx_data   last byte written by the initiator.
//   o_rx_valid  one-cycle pulse when o_rx_data updates.
//   o_addr_hit  one-cycle pulse on an address match.
//   o_rw        R/W bit of the current transaction (1 = read).
//   o_busy      high from START until STOP.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module iic_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_SCL,
  inout  wire        io_SDA,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_addr_hit,
  output logic       o_rw,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  // Input synchronizers, plus one extra "previous" stage used for edge detection
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  // FSM and datapath state
  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        bit_done_q, bit_done_d;
  logic        mack_q, mack_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        addr_hit_q, addr_hit_d;
  logic        tx_req_q, tx_req_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;

  // Decoded bus events
  logic        sda_in;
  logic        scl_now, sda_now;
  logic        scl_rise, scl_fall;
  logic        start_det, stop_det;
  logic [7:0]  shift_in;
  logic        addr_match;

  // The target only ever pulls SDA low; a released line floats high via the pull-up
  assign io_SDA = sda_oe_q ? 1'b0 : 1'bz;
  assign sda_in = io_SDA;

  // Shift each synchronizer chain by one stage per clock, taking the raw bus pins at the bottom
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_SCL};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Bus events come from comparing the synchronized level with its previous value.
  // START and STOP require SCL high on both samples, so an SDA change caused by
  // SCL skew cannot be mistaken for a bus condition.
  always_comb begin
    scl_now    = scl_sync_q[SYNC_STAGES-1];
    sda_now    = sda_sync_q[SYNC_STAGES-1];
    scl_rise   = !scl_prev_q &&  scl_now;
    scl_fall   =  scl_prev_q && !scl_now;
    start_det  = scl_now && scl_prev_q &&  sda_prev_q && !sda_now;
    stop_det   = scl_now && scl_prev_q && !sda_prev_q &&  sda_now;
    shift_in   = {shreg_q[6:0], sda_now};
    addr_match = (shift_in[7:1] == TARGET_ADDR);
  end

  // Synchronizer registers preset to 1 (the idle bus level) so that leaving reset
  // cannot produce a false START
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. STOP outranks START, and both outrank SCL edges, so a
  // repeated START can abort any partially shifted byte.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ADDR: begin
          if (scl_rise && !bit_done_q && (bit_cnt_q == 3'd7) && !addr_match) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall && bit_done_q) begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            state_d = rw_q ? ST_RD_DATA : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (scl_fall && bit_done_q) begin
            state_d = ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            state_d = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          if (scl_fall && (bit_cnt_q == 3'd7)) begin
            state_d = ST_RD_ACK;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_now) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall && mack_q) begin
            state_d = ST_RD_DATA;
          end
        end
        ST_WAIT_STOP: begin
          state_d = ST_WAIT_STOP;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      bit_done_q <= 1'b0;
      mack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_done_q <= bit_done_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  // Output and datapath logic.
  // The bit counter stops at 7 and raises bit_done. The byte therefore
  // completes with a flag rather than by wrapping into the ACK slot. Any
  // change to the SDA drive happens only in a cycle where an SCL fall is
  // detected, which keeps SDA stable while SCL is high.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    bit_done_d = bit_done_q;
    mack_d     = mack_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;

    if (stop_det) begin
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      bit_cnt_d  = 3'd0;
      bit_done_d = 1'b0;
      mack_d     = 1'b0;
    end else if (start_det) begin
      sda_oe_d   = 1'b0;
      busy_d     = 1'b1;
      bit_cnt_d  = 3'd0;
      bit_done_d = 1'b0;
      mack_d     = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise && !bit_done_q) begin
            shreg_d = shift_in;
            if (bit_cnt_q == 3'd7) begin
              if (addr_match) begin
                rw_d       = shift_in[0];
                addr_hit_d = 1'b1;
                bit_done_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (scl_fall && bit_done_q) begin
            // The address ACK starts here. On a read, the first data byte is
            // requested now so that it is ready when the ACK slot ends.
            sda_oe_d   = 1'b1;
            tx_req_d   = rw_q;
            bit_done_d = 1'b0;
            bit_cnt_d  = 3'd0;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d  = 3'd0;
            bit_done_d = 1'b0;
            if (rw_q) begin
              shreg_d  = i_tx_data;
              sda_oe_d = ~i_tx_data[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise && !bit_done_q) begin
            shreg_d = shift_in;
            if (bit_cnt_q == 3'd7) begin
              bit_done_d = 1'b1;
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (scl_fall && bit_done_q) begin
            sda_oe_d   = 1'b1;
            bit_done_d = 1'b0;
            bit_cnt_d  = 3'd0;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end
        ST_RD_DATA: begin
          // The MSB was already placed on the bus on entry. Each fall presents
          // the next bit, and the fall after bit 0 frees the line for the
          // initiator's ACK or NACK.
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              mack_d    = 1'b0;
              bit_cnt_d = 3'd0;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_oe_d  = ~shreg_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && !sda_now) begin
            mack_d   = 1'b1;
            tx_req_d = 1'b1;
          end else if (scl_fall && mack_q) begin
            shreg_d   = i_tx_data;
            sda_oe_d  = ~i_tx_data[7];
            bit_cnt_d = 3'd0;
            mack_d    = 1'b0;
          end
        end
        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign o_tx_req   = tx_req_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_addr_hit = addr_hit_q;
  assign o_rw       = rw_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_iic_target.sv
// -----------------------------------------------------------------------------
// tb_iic_target
//
// Testbench for iic_target. It plays the bus initiator by bit-banging SCL and
// an open-drain SDA. Each scenario task checks its results against
// expectations built from the I2C transaction itself: address match, ACK
// slots, the bytes written, and the bytes queued for reads.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_iic_target;

  localparam int Q = 80;  // quarter SCL period in ns (SCL period = 32 system clocks)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  logic [7:0] tx_data;
  wire        sda;

  logic       o_tx_req;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_addr_hit;
  logic       o_rw;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  int n_hit = 0;
  int n_rxv = 0;
  int n_txr = 0;
  int n_drv = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  iic_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_SCL      (scl),
    .io_SDA     (sda),
    .i_tx_data  (tx_data),
    .o_tx_req   (o_tx_req),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .o_addr_hit (o_addr_hit),
    .o_rw       (o_rw),
    .o_busy     (o_busy)
  );

  // Pulse monitor: counts pulses, records received bytes, and serves read
  // bytes from tx_q whenever the target requests one
  always @(negedge clk) begin
    if (o_addr_hit) n_hit++;
    if (o_rx_valid) begin
      n_rxv++;
      rx_q.push_back(o_rx_data);
    end
    if (o_tx_req) begin
      n_txr++;
      tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
    end
    if (!m_low && sda === 1'b0) n_drv++;
  end

  // Bus primitives; SCL is low on entry and exit except START from idle
  task automatic bus_start();
    m_low = 1'b0; scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #Q; #Q;
  endtask

  task automatic bus_bit(input logic b, output logic r);
    m_low = !b; #Q;
    scl = 1'b1; #Q;
    r = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic bus_byte(input logic [7:0] d, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(d[i], rb);
      r[i] = rb;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (o_rx_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_rx_data: got %h want %h", o_rx_data, 8'h00); end
    total++; if (o_rw !== 1'b0) begin bad++; $display("[TB] FAIL rst_rw: got %b want 0", o_rw); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", o_busy); end
    total++; if ({o_addr_hit, o_rx_valid, o_tx_req} !== 3'b000) begin bad++; $display("[TB] FAIL rst_pulses: got %b want 000", {o_addr_hit, o_rx_valid, o_tx_req}); end
    total++; if (sda !== 1'b1) begin bad++; $display("[TB] FAIL rst_sda: got %b want 1", sda); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] d [2];
    logic [7:0] r;
    logic ack;
    int h0, v0;
    d[0] = 8'hA5; d[1] = 8'h3C;
    h0 = n_hit; v0 = n_rxv; rx_q.delete();
    bus_start();
    total++; if (o_busy !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy_on: got %b want 1", o_busy); end
    bus_byte(8'hA0, r); bus_bit(1'b1, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL wr_addr_ack: got %b want 0", ack); end
    total++; if (o_rw !== 1'b0) begin bad++; $display("[TB] FAIL wr_rw: got %b want 0", o_rw); end
    for (int i = 0; i < 2; i++) begin
      bus_byte(d[i], r); bus_bit(1'b1, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL wr_data_ack%0d: got %b want 0", i, ack); end
    end
    bus_stop();
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL wr_busy_off: got %b want 0", o_busy); end
    total++; if (n_hit - h0 != 1) begin bad++; $display("[TB] FAIL wr_hits: got %0d want 1", n_hit - h0); end
    total++; if (n_rxv - v0 != 2) begin bad++; $display("[TB] FAIL wr_rx_valid: got %0d want 2", n_rxv - v0); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rx_q.size() <= i || rx_q[i] !== d[i]) begin
        bad++; $display("[TB] FAIL wr_rx_byte%0d: got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, d[i]);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] r;
    logic ack;
    int h0, v0, dr0;
    h0 = n_hit; v0 = n_rxv; dr0 = n_drv;
    bus_start();
    bus_byte(8'hA2, r); bus_bit(1'b1, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("[TB] FAIL mm_addr_ack: got %b want 1", ack); end
    bus_byte(8'h11, r); bus_bit(1'b1, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("[TB] FAIL mm_data_ack: got %b want 1", ack); end
    bus_stop();
    total++; if (n_drv != dr0) begin bad++; $display("[TB] FAIL mm_sda_driven: got %0d cycles want 0", n_drv - dr0); end
    total++; if (n_hit != h0) begin bad++; $display("[TB] FAIL mm_hits: got %0d want 0", n_hit - h0); end
    total++; if (n_rxv != v0) begin bad++; $display("[TB] FAIL mm_rx_valid: got %0d want 0", n_rxv - v0); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL mm_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_read();
    logic [7:0] r;
    logic ack, rb;
    int t0;
    tx_q.delete(); tx_q.push_back(8'hC3); tx_q.push_back(8'h5A);
    t0 = n_txr;
    bus_start();
    bus_byte(8'hA1, r); bus_bit(1'b1, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL rd_addr_ack: got %b want 0", ack); end
    total++; if (o_rw !== 1'b1) begin bad++; $display("[TB] FAIL rd_rw: got %b want 1", o_rw); end
    bus_byte(8'hFF, r); bus_bit(1'b0, rb);
    total++; if (r !== 8'hC3) begin bad++; $display("[TB] FAIL rd_byte0: got %h want %h", r, 8'hC3); end
    bus_byte(8'hFF, r); bus_bit(1'b1, rb);
    total++; if (r !== 8'h5A) begin bad++; $display("[TB] FAIL rd_byte1: got %h want %h", r, 8'h5A); end
    bus_bit(1'b1, rb);
    total++; if (rb !== 1'b1) begin bad++; $display("[TB] FAIL rd_released_after_nack: got %b want 1", rb); end
    bus_stop();
    total++; if (n_txr - t0 != 2) begin bad++; $display("[TB] FAIL rd_tx_req: got %0d want 2", n_txr - t0); end
  endtask

  task automatic test_repeated_start();
    logic [7:0] r;
    logic ack, rb;
    int h0;
    tx_q.delete(); tx_q.push_back(8'h81);
    h0 = n_hit; rx_q.delete();
    bus_start();
    bus_byte(8'hA0, r); bus_bit(1'b1, ack);
    bus_byte(8'h07, r); bus_bit(1'b1, ack);
    total++; if (o_rw !== 1'b0) begin bad++; $display("[TB] FAIL sr_rw_before: got %b want 0", o_rw); end
    bus_rstart();
    bus_byte(8'hA1, r); bus_bit(1'b1, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL sr_addr_ack: got %b want 0", ack); end
    total++; if (o_rw !== 1'b1) begin bad++; $display("[TB] FAIL sr_rw_after: got %b want 1", o_rw); end
    bus_byte(8'hFF, r); bus_bit(1'b1, rb);
    total++; if (r !== 8'h81) begin bad++; $display("[TB] FAIL sr_read: got %h want %h", r, 8'h81); end
    bus_stop();
    total++; if (o_rx_data !== 8'h07) begin bad++; $display("[TB] FAIL sr_rx_data: got %h want %h", o_rx_data, 8'h07); end
    total++; if (n_hit - h0 != 2) begin bad++; $display("[TB] FAIL sr_hits: got %0d want 2", n_hit - h0); end
  endtask

  task automatic test_stop_mid_byte();
    logic [7:0] r;
    logic ack, rb;
    int v0;
    v0 = n_rxv;
    bus_start();
    bus_byte(8'hA0, r); bus_bit(1'b1, ack);
    bus_bit(1'b1, rb); bus_bit(1'b0, rb); bus_bit(1'b1, rb); bus_bit(1'b1, rb);
    bus_stop();
    total++; if (n_rxv != v0) begin bad++; $display("[TB] FAIL smb_rx_valid: got %0d want 0", n_rxv - v0); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL smb_busy: got %b want 0", o_busy); end
    bus_start();
    bus_byte(8'hA0, r); bus_bit(1'b1, ack);
    bus_byte(8'h99, r); bus_bit(1'b1, ack);
    bus_stop();
    total++; if (o_rx_data !== 8'h99) begin bad++; $display("[TB] FAIL smb_rx_data: got %h want %h", o_rx_data, 8'h99); end
    total++; if (n_rxv - v0 != 1) begin bad++; $display("[TB] FAIL smb_rx_count: got %0d want 1", n_rxv - v0); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] r;
    logic ack, rb;
    int h0, v0, t0, dr0;
    tx_q.delete(); tx_q.push_back(8'h00);
    bus_start();
    bus_byte(8'hA1, r); bus_bit(1'b1, ack);
    total++; if (sda !== 1'b0) begin bad++; $display("[TB] FAIL rmr_sda_before: got %b want 0", sda); end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    total++; if (sda !== 1'b1) begin bad++; $display("[TB] FAIL rmr_sda_released: got %b want 1", sda); end
    total++; if ({o_busy, o_rw, o_rx_data} !== 10'h000) begin bad++; $display("[TB] FAIL rmr_outputs: got busy=%b rw=%b rx=%h want 0 0 00", o_busy, o_rw, o_rx_data); end
    h0 = n_hit; v0 = n_rxv; t0 = n_txr; dr0 = n_drv;
    for (int i = 0; i < 9; i++) bus_bit(1'b1, rb);
    bus_stop();
    total++; if (n_drv != dr0) begin bad++; $display("[TB] FAIL rmr_quiet_sda: got %0d cycles want 0", n_drv - dr0); end
    total++; if ((n_hit - h0) + (n_rxv - v0) + (n_txr - t0) != 0) begin bad++; $display("[TB] FAIL rmr_quiet_pulses: got %0d want 0", (n_hit - h0) + (n_rxv - v0) + (n_txr - t0)); end
  endtask

  // Random transactions checked against the transaction-level expectations
  task automatic test_random();
    logic [7:0] r, d;
    logic ack, rb, rw, match;
    logic [6:0] a;
    logic [7:0] exp_q[$];
    int n, h0, t0, dr0;
    for (int k = 0; k < 8; k++) begin
      rw    = 1'($urandom_range(0, 1));
      match = ($urandom_range(0, 3) != 0);
      a     = 7'h50;
      if (!match) begin
        do a = 7'($urandom_range(0, 127)); while (a == 7'h50);
      end
      n = $urandom_range(1, 3);
      exp_q.delete(); rx_q.delete(); tx_q.delete();
      h0 = n_hit; t0 = n_txr; dr0 = n_drv;
      if (rw && match) begin
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          tx_q.push_back(d); exp_q.push_back(d);
        end
      end
      bus_start();
      bus_byte({a, rw}, r); bus_bit(1'b1, ack);
      total++; if (ack !== !match) begin bad++; $display("[TB] FAIL rnd%0d_addr_ack: got %b want %b", k, ack, !match); end
      if (!rw) begin
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          if (match) exp_q.push_back(d);
          bus_byte(d, r); bus_bit(1'b1, ack);
          total++; if (ack !== !match) begin bad++; $display("[TB] FAIL rnd%0d_wr_ack%0d: got %b want %b", k, i, ack, !match); end
        end
        bus_stop();
        total++;
        if (rx_q.size() != exp_q.size()) begin
          bad++; $display("[TB] FAIL rnd%0d_rx_count: got %0d want %0d", k, rx_q.size(), exp_q.size());
        end else begin
          for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rnd%0d_rx%0d: got %h want %h", k, i, rx_q[i], exp_q[i]); end
          end
        end
      end else if (match) begin
        for (int i = 0; i < n; i++) begin
          bus_byte(8'hFF, r); bus_bit((i == n - 1), rb);
          total++; if (r !== exp_q[i]) begin bad++; $display("[TB] FAIL rnd%0d_rd%0d: got %h want %h", k, i, r, exp_q[i]); end
        end
        bus_stop();
        total++; if (n_txr - t0 != n) begin bad++; $display("[TB] FAIL rnd%0d_tx_req: got %0d want %0d", k, n_txr - t0, n); end
      end else begin
        bus_stop();
        total++; if (n_drv != dr0) begin bad++; $display("[TB] FAIL rnd%0d_sda_driven: got %0d want 0", k, n_drv - dr0); end
      end
      total++; if (n_hit - h0 != int'(match)) begin bad++; $display("[TB] FAIL rnd%0d_hits: got %0d want %0d", k, n_hit - h0, int'(match)); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_repeated_start();
    test_stop_mid_byte();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900us;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
